uut_batch_runner: RTL and testbench

UUT_BATCH_RUNNER -- requirements
Module: uut_batch_runner

---
 rtl/uut_batch_runner.sv | 191 +++++++++++++++++++
 tb/tb_uut_batch_runner.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uut_batch_runner.sv
// Batch runner: buffers input blocks, then runs the UUT on each under reset/run control and compares its final result.
// Optional per-block watchdog enabled by defining UUT_BATCH_WATCHDOG_EN.
module uut_batch_runner #(
  parameter int IN_WIDTH       = 64,
  parameter int OUT_WIDTH      = 128,
  parameter int MAX_BLOCKS     = 8,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int BW            = $clog2(MAX_BLOCKS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BW-1:0]        num_blocks,
  input  logic [IN_WIDTH-1:0]  blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [OUT_WIDTH-1:0] expected,
  output logic                 rst_uut,
  output logic [IN_WIDTH-1:0]  input_to_uut,
  input  logic                 end_uut,
  input  logic                 err_uut,
  input  logic [OUT_WIDTH-1:0] output_from_uut,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic                 err,
  output logic [OUT_WIDTH-1:0] result,
  output logic [31:0]          cycle_count,
  input  logic [1:0]           sw_debug,
  output logic [31:0]          debug
);

  localparam int AW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RST, RUN, NEXT, CHECK, DONE} state_t;

  state_t               state, state_nx;
  logic [BW-1:0]        n_blocks, wr_idx, idx;
  logic [OUT_WIDTH-1:0] expected_r;
  logic [31:0]          rst_cnt;
  logic [IN_WIDTH-1:0]  buffer [0:MAX_BLOCKS-1];
  logic                 nb_ok, load_last, rst_last, next_last, wd_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign nb_ok     = (num_blocks != '0) && (num_blocks <= BW'(MAX_BLOCKS));
  assign load_last = blk_valid && (BW'(wr_idx + 1'b1) == n_blocks);
  assign rst_last  = (rst_cnt == 32'(RST_CYCLES - 1));
  assign next_last = (BW'(idx + 1'b1) == n_blocks);

`ifdef UUT_BATCH_WATCHDOG_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wd_cnt <= '0;
    else if (state == RST)  wd_cnt <= '0;
    else if (state == RUN)  wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_hit = (state == RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // err_uut outranks end_uut, which outranks the watchdog
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    blk_ready = 1'b0;
    rst_uut   = 1'b1;
    case (state)
      IDLE: if (start) state_nx = nb_ok ? LOAD : DONE;
      LOAD: begin
        busy      = 1'b1;
        blk_ready = 1'b1;
        if (load_last) state_nx = RST;
      end
      RST: begin
        busy = 1'b1;
        if (rst_last) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        rst_uut = 1'b0;
        if (err_uut)      state_nx = DONE;
        else if (end_uut) state_nx = NEXT;
        else if (wd_hit)  state_nx = DONE;
      end
      NEXT: begin
        busy     = 1'b1;
        rst_uut  = 1'b0;
        state_nx = next_last ? CHECK : RST;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = nb_ok ? LOAD : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_blocks    <= '0;
      wr_idx      <= '0;
      idx         <= '0;
      rst_cnt     <= '0;
      expected_r  <= '0;
      result      <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          pass    <= 1'b0;
          fail    <= 1'b0;
          timeout <= 1'b0;
          if (nb_ok) begin
            err         <= 1'b0;
            n_blocks    <= num_blocks;
            expected_r  <= expected;
            result      <= '0;
            cycle_count <= '0;
            wr_idx      <= '0;
            idx         <= '0;
          end else begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          rst_cnt <= '0;
          if (blk_valid) wr_idx <= wr_idx + 1'b1;
        end
        RST: rst_cnt <= rst_cnt + 32'd1;
        RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (err_uut)      err     <= 1'b1;
          else if (end_uut) result  <= output_from_uut;
          else if (wd_hit)  timeout <= 1'b1;
        end
        NEXT: begin
          idx     <= idx + 1'b1;
          rst_cnt <= '0;
        end
        CHECK: begin
          pass <= (result == expected_r);
          fail <= (result != expected_r);
        end
        default: ;
      endcase
    end
  end

  // Block storage carries no reset; contents are don't-care until loaded
  always_ff @(posedge clk) begin
    if (state == LOAD && blk_valid) buffer[wr_idx[AW-1:0]] <= blk_data;
  end

  assign input_to_uut = (state == RST || state == RUN || state == NEXT) ?
                        buffer[idx[AW-1:0]] : '0;

  always_comb begin
    case (sw_debug)
      2'd0:    debug = cycle_count;
      2'd1:    debug = result[31:0];
      2'd2:    debug = {26'b0, busy, done, pass, fail, timeout, err};
      default: debug = {13'b0, state, 16'(idx)};
    endcase
  end

endmodule

// File: tb/tb_uut_batch_runner.sv
// Testbench for uut_batch_runner: stub UUT answers {~in,in} after 10 run cycles; batches checked against a queue-based model.
module tb_uut_batch_runner;

  localparam int IN_W = 64;
  localparam int OUT_W = 128;
  localparam int MAXB = 8;
  localparam int RSTC = 2;
  localparam int TMO = 16;
  localparam int BW = $clog2(MAXB) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [BW-1:0]    num_blocks = '0;
  logic [IN_W-1:0]  blk_data = '0;
  logic             blk_valid = 1'b0;
  logic             blk_ready;
  logic [OUT_W-1:0] expected = '0;
  logic             rst_uut;
  logic [IN_W-1:0]  input_to_uut;
  logic             end_uut, err_uut;
  logic [OUT_W-1:0] output_from_uut;
  logic             busy, done, pass, fail, timeout, err;
  logic [OUT_W-1:0] result;
  logic [31:0]      cycle_count, debug;
  logic [1:0]       sw_debug = 2'd0;

  int checks = 0;
  int failures = 0;

  logic [31:0] stub_cnt = '0;
  bit          stub_hang = 1'b0;
  bit          err_en = 1'b0;
  bit          noise_en = 1'b0;
  logic        noise_bit = 1'b0;
  int          err_blk = 0;
  int          err_at = 0;

  int          run_starts = 0;
  int          hi_len = 0;
  logic        prev_rst = 1'b1;
  logic [63:0] seen_in[$];
  int          pulse_lens[$];
  logic [63:0] blks [8];

  uut_batch_runner #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .MAX_BLOCKS(MAXB),
    .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .expected(expected), .rst_uut(rst_uut), .input_to_uut(input_to_uut),
    .end_uut(end_uut), .err_uut(err_uut), .output_from_uut(output_from_uut),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err(err), .result(result), .cycle_count(cycle_count),
    .sw_debug(sw_debug), .debug(debug)
  );

  always #5 clk = ~clk;

  // Stub UUT: finishes on its 10th cycle out of reset, noisy end_uut while held in reset
  always @(posedge clk) stub_cnt <= rst_uut ? 32'd0 : stub_cnt + 32'd1;
  assign output_from_uut = {~input_to_uut, input_to_uut};
  assign end_uut = rst_uut ? noise_bit : (!stub_hang && stub_cnt == 32'd9);
  assign err_uut = err_en && !rst_uut && (run_starts == err_blk) && (stub_cnt == 32'(err_at));

  always @(negedge clk) begin
    noise_bit = noise_en ? 1'($urandom % 2) : 1'b0;
    if (!rst_uut) begin
      if (prev_rst) begin
        run_starts++;
        seen_in.push_back(input_to_uut);
        pulse_lens.push_back(hi_len);
      end
      hi_len = 0;
    end else begin
      hi_len++;
    end
    prev_rst = rst_uut;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded, got=running required=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input int n, input logic [127:0] e);
    run_starts = 0;
    seen_in.delete();
    pulse_lens.delete();
    num_blocks = BW'(n);
    expected = e;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every block, 2 random idle cycles
  task automatic feed(input int n, input int gap_mode, input bit start_noise);
    for (int i = 0; i < n; i++) begin
      int k;
      blk_valid = 1'b0;
      if (gap_mode == 1) tick();
      else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
      blk_data = blks[i];
      blk_valid = 1'b1;
      if (start_noise) begin
        start = 1'b1;
        num_blocks = '0;
      end
      k = 0;
      while (!blk_ready && k < 50) begin
        tick();
        k++;
      end
      if (!blk_ready) chk("blk_ready_wait", blk_ready, 1);
      tick();
    end
    blk_valid = 1'b0;
    blk_data = '0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic check_batch(input int n, input logic [127:0] e, input string tag);
    logic [63:0]  last;
    logic [127:0] r;
    bit           p;
    last = blks[n-1];
    r = {~last, last};
    p = (r == e);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":pass"}, pass, p);
    chk({tag, ":fail"}, fail, !p);
    chk({tag, ":err"}, err, 0);
    chk({tag, ":timeout"}, timeout, 0);
    chk({tag, ":result"}, result, r);
    chk({tag, ":cycle_count"}, cycle_count, 32'(10 * n));
    chk({tag, ":run_starts"}, run_starts, n);
    chk({tag, ":rst_uut_done"}, rst_uut, 1);
    for (int i = 0; i < n && i < seen_in.size(); i++)
      chk({tag, ":uut_input"}, seen_in[i], blks[i]);
    for (int i = 1; i < n && i < pulse_lens.size(); i++)
      chk({tag, ":rst_pulse_len"}, pulse_lens[i], RSTC);
    sw_debug = 2'd2;
    #1 chk({tag, ":debug_status"}, debug, {26'b0, 1'b0, 1'b1, p, !p, 2'b00});
    sw_debug = 2'd0;
    #1 chk({tag, ":debug_cycles"}, debug, 32'(10 * n));
    sw_debug = 2'd1;
    #1 chk({tag, ":debug_result"}, debug, r[31:0]);
    sw_debug = 2'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ":rst_uut"}, rst_uut, 1);
    chk({tag, ":blk_ready"}, blk_ready, 0);
    chk({tag, ":input_to_uut"}, input_to_uut, 0);
    chk({tag, ":status"}, {busy, done, pass, fail, timeout, err}, 0);
    chk({tag, ":result"}, result, 0);
    chk({tag, ":cycle_count"}, cycle_count, 0);
    chk({tag, ":debug_state_idx"}, debug, 0);
  endtask

  initial begin
    logic [127:0] e;
    int           n;
    int           k;

    #2 rst = 1'b1;
    sw_debug = 2'd3;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    sw_debug = 2'd0;

    // Single block, matching golden value
    blks[0] = 64'h1234567812345678;
    e = {~blks[0], blks[0]};
    start_batch(1, e);
    feed(1, 0, 1'b0);
    wait_done(200);
    check_batch(1, e, "single");

    // Three blocks with gapped valid, spurious start while busy
    blks[0] = 64'd1; blks[1] = 64'd2; blks[2] = 64'd3;
    e = {~64'd3, 64'd3};
    start_batch(3, e);
    feed(3, 1, 1'b1);
    wait_done(300);
    check_batch(3, e, "three_gapped");

    // Wrong golden value
    blks[0] = 64'hDEAD_BEEF_0000_0001; blks[1] = 64'hCAFE_F00D_0000_0002;
    start_batch(2, '0);
    feed(2, 0, 1'b0);
    wait_done(300);
    check_batch(2, '0, "mismatch");

    // Out-of-range block counts
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 0 : MAXB + 1;
      start_batch(n, '0);
      tick();
      chk("badcount:done", done, 1);
      chk("badcount:err", err, 1);
      chk("badcount:busy", busy, 0);
      chk("badcount:pass_fail", {pass, fail, timeout}, 0);
      chk("badcount:rst_uut", rst_uut, 1);
      chk("badcount:run_starts", run_starts, 0);
    end

    // err_uut on block 2 in the same cycle as end_uut, then mid-run on block 1
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 3; i++) blks[i] = {$urandom, $urandom};
      err_en = 1'b1;
      err_blk = (t == 0) ? 2 : 1;
      err_at = (t == 0) ? 9 : $urandom_range(0, 8);
      start_batch(3, {~blks[2], blks[2]});
      feed(3, 2, 1'b0);
      wait_done(300);
      err_en = 1'b0;
      chk("uut_err:err", err, 1);
      chk("uut_err:others", {pass, fail, timeout, busy}, 0);
      chk("uut_err:result", result, (t == 0) ? {~blks[0], blks[0]} : 128'd0);
      chk("uut_err:cycle_count", cycle_count, 32'((t == 0 ? 10 : 0) + err_at + 1));
      chk("uut_err:run_starts", run_starts, err_blk);
    end

    // UUT that never finishes
    blks[0] = {$urandom, $urandom};
    stub_hang = 1'b1;
    start_batch(1, '0);
    feed(1, 0, 1'b0);
`ifdef UUT_BATCH_WATCHDOG_EN
    wait_done(300);
    chk("watchdog:timeout", timeout, 1);
    chk("watchdog:others", {pass, fail, err, busy}, 0);
    chk("watchdog:cycle_count", cycle_count, TMO);
    chk("watchdog:rst_uut", rst_uut, 1);
`else
    repeat (100) tick();
    chk("no_watchdog:busy", busy, 1);
    chk("no_watchdog:timeout", {timeout, done}, 0);
    chk("no_watchdog:running", cycle_count > 32'd50, 1);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    stub_hang = 1'b0;

    // Asynchronous reset while block 2 runs
    for (int i = 0; i < 3; i++) blks[i] = {$urandom, $urandom};
    start_batch(3, {~blks[2], blks[2]});
    feed(3, 0, 1'b0);
    k = 0;
    while (run_starts < 2 && k < 200) begin
      tick();
      k++;
    end
    chk("midrun:reached_block2", run_starts, 2);
    repeat (3) tick();
    sw_debug = 2'd3;
    #2 rst = 1'b1;
    #1 check_reset_state("midrun_reset");
    tick();
    rst = 1'b0;
    sw_debug = 2'd0;
    e = {~blks[2], blks[2]};
    start_batch(3, e);
    feed(3, 0, 1'b0);
    wait_done(300);
    check_batch(3, e, "after_reset");

    // Randomized batches
    noise_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, MAXB);
      for (int i = 0; i < MAXB; i++) blks[i] = {$urandom, $urandom};
      if ($urandom % 2) e = {~blks[n-1], blks[n-1]};
      else e = {$urandom, $urandom, $urandom, $urandom};
      start_batch(n, e);
      feed(n, 2, 1'($urandom % 2));
      wait_done(n * 40 + 100);
      check_batch(n, e, "random");
    end
    noise_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
